// File: rtl/bandai2003_eeprom_port.sv
// Microwire (93Cxx) EEPROM controller behind the cartridge mapper port window.
// Register accesses start read, write+poll or command-only transactions on EE_CS/SK/DI/DO.
module bandai2003_eeprom_port #(
    parameter int ADDR_W       = 6,
    parameter int SK_DIV       = 4,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REG_WR,
    input  logic       REG_RD,
    input  logic [2:0] REG_A,
    input  logic [7:0] REG_WD,
    output logic [7:0] REG_RDAT,
    output logic       EE_CS,
    output logic       EE_SK,
    output logic       EE_DI,
    input  logic       EE_DO,
    output logic       BUSY
);
    localparam int CMD_BITS = ADDR_W + 3;
    localparam int TW       = $clog2(2 * SK_DIV + 1);
    localparam int PW       = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;
    localparam logic [2:0] S_DESEL = 3'd5;
    localparam logic [2:0] S_POLL  = 3'd6;

    localparam logic [TW-1:0] HALF_END = TW'(SK_DIV - 1);
    localparam logic [TW-1:0] SK_HI    = TW'(SK_DIV);
    localparam logic [TW-1:0] BIT_END  = TW'(2 * SK_DIV - 1);
    localparam logic [5:0]    CMD_END  = 6'(CMD_BITS - 1);
    localparam logic [5:0]    DAT_END  = 6'd15;
    localparam logic [PW-1:0] TMO_END  = PW'(BUSY_TIMEOUT - 1);

    logic [2:0]          state, nstate;
    logic [TW-1:0]       tick, ntick;
    logic [5:0]          bitn, nbit;
    logic [PW-1:0]       pcnt;
    logic [15:0]         data, cmd;
    logic                done, err, op_rd, op_wr, poll_en, ok1;
    logic                fin, tmo;
    logic                ctrl_wr, abort, go;
    logic [CMD_BITS-1:0] cmd_vec, cmd_sh;
    logic [15:0]         dat_sh;
    logic                unused;

    assign BUSY    = (state != S_IDLE);
    assign ctrl_wr = REG_WR && (REG_A == 3'd4);
    assign abort   = ctrl_wr && REG_WD[7];
    assign go      = ctrl_wr && !REG_WD[7] && (|REG_WD[6:4]) && (state == S_IDLE);
    assign unused  = &{1'b0, REG_WD[2:1]};

    // Serial bit streams are picked by shifting so the outgoing bit is always the MSB.
    assign cmd_vec = {1'b1, cmd[ADDR_W+1:0]};
    assign cmd_sh  = cmd_vec << nbit;
    assign dat_sh  = data << nbit;

    always_comb begin
        nstate = state;
        ntick  = tick;
        nbit   = bitn;
        fin    = 1'b0;
        tmo    = 1'b0;
        case (state)
            S_SEL: begin
                if (tick == HALF_END) begin
                    nstate = S_CMD;
                    ntick  = '0;
                    nbit   = '0;
                end else begin
                    ntick = tick + 1'b1;
                end
            end
            S_CMD, S_RDATA, S_WDATA: begin
                if (tick == BIT_END) begin
                    ntick = '0;
                    if (bitn == ((state == S_CMD) ? CMD_END : DAT_END)) begin
                        nbit = '0;
                        if (state == S_CMD && op_rd)      nstate = S_RDATA;
                        else if (state == S_CMD && op_wr) nstate = S_WDATA;
                        else                              nstate = S_DESEL;
                    end else begin
                        nbit = bitn + 1'b1;
                    end
                end else begin
                    ntick = tick + 1'b1;
                end
            end
            S_DESEL: begin
                if (tick == BIT_END) begin
                    ntick  = '0;
                    nstate = poll_en ? S_POLL : S_IDLE;
                    fin    = !poll_en;
                end else begin
                    ntick = tick + 1'b1;
                end
            end
            S_POLL: begin
                if (EE_DO && ok1) begin
                    nstate = S_IDLE;
                    fin    = 1'b1;
                end else if (pcnt == TMO_END) begin
                    nstate = S_IDLE;
                    fin    = 1'b1;
                    tmo    = 1'b1;
                end
            end
            S_IDLE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
        if (abort) begin
            nstate = S_IDLE;
            ntick  = '0;
            nbit   = '0;
            fin    = 1'b0;
            tmo    = 1'b0;
        end else if (go) begin
            nstate = S_SEL;
            ntick  = '0;
            nbit   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            tick     <= '0;
            bitn     <= '0;
            pcnt     <= '0;
            ok1      <= 1'b0;
            data     <= 16'h0000;
            cmd      <= 16'h0000;
            done     <= 1'b0;
            err      <= 1'b0;
            op_rd    <= 1'b0;
            op_wr    <= 1'b0;
            poll_en  <= 1'b0;
            EE_CS    <= 1'b0;
            EE_SK    <= 1'b0;
            EE_DI    <= 1'b0;
            REG_RDAT <= 8'h00;
        end else begin
            state <= nstate;
            tick  <= ntick;
            bitn  <= nbit;
            // Pins are registered from the next state so they line up with it cycle for cycle.
            EE_CS <= (nstate == S_SEL) || (nstate == S_CMD) || (nstate == S_RDATA) ||
                     (nstate == S_WDATA) || (nstate == S_POLL);
            EE_SK <= ((nstate == S_CMD) || (nstate == S_RDATA) || (nstate == S_WDATA)) &&
                     (ntick >= SK_HI);
            EE_DI <= (nstate == S_CMD)   ? cmd_sh[CMD_BITS-1] :
                     (nstate == S_WDATA) ? dat_sh[15] : 1'b0;
            pcnt  <= (state == S_POLL) ? pcnt + 1'b1 : '0;
            ok1   <= (state == S_POLL) && EE_DO;

            if (go) begin
                op_rd   <= REG_WD[4];
                op_wr   <= !REG_WD[4] && REG_WD[5];
                poll_en <= !REG_WD[4] && (REG_WD[5] || REG_WD[3]);
            end

            if (ctrl_wr && REG_WD[0]) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (go)  done <= 1'b0;
            if (fin) done <= 1'b1;
            if (tmo) err  <= 1'b1;

            if (REG_WR && state == S_IDLE) begin
                case (REG_A)
                    3'd0:    data[7:0]  <= REG_WD;
                    3'd1:    data[15:8] <= REG_WD;
                    3'd2:    cmd[7:0]   <= REG_WD;
                    3'd3:    cmd[15:8]  <= REG_WD;
                    default: ;
                endcase
            end
            // DO is captured on the first SK-high cycle of each read bit.
            if (state == S_RDATA && tick == SK_HI)
                data <= {data[14:0], EE_DO};

            if (REG_RD) begin
                case (REG_A)
                    3'd0:    REG_RDAT <= data[7:0];
                    3'd1:    REG_RDAT <= data[15:8];
                    3'd2:    REG_RDAT <= cmd[7:0];
                    3'd3:    REG_RDAT <= cmd[15:8];
                    3'd4:    REG_RDAT <= {BUSY, 5'b0, err, done};
                    default: REG_RDAT <= 8'hFF;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bandai2003_eeprom_port.sv
// Bench for bandai2003_eeprom_port: behavioural 93Cxx model plus scoreboards for
// register reads and serial DI bits.
module tb_bandai2003_eeprom_port;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REG_WR = 1'b0;
    logic       REG_RD = 1'b0;
    logic [2:0] REG_A = 3'd0;
    logic [7:0] REG_WD = 8'h00;
    logic [7:0] REG_RDAT;
    logic       EE_CS, EE_SK, EE_DI, BUSY;
    logic       EE_DO = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rd_exp_q[$];
    string       rd_tag_q[$];
    logic        di_q[$];
    bit          di_en = 1'b0;
    int          mode = 0;
    logic [15:0] rom = 16'hBEEF;
    logic [15:0] rom_sh;
    int          cs_rises = 0, falls = 0, skr = 0, cslow = 0, polln = 0;
    logic        busy_p = 1'b0, cs_p = 1'b0, sk_p = 1'b0, rd_d = 1'b0;
    int          n;

    bandai2003_eeprom_port #(.ADDR_W(6), .SK_DIV(2), .BUSY_TIMEOUT(100)) dut (
        .CLK(CLK), .RST(RST), .REG_WR(REG_WR), .REG_RD(REG_RD), .REG_A(REG_A),
        .REG_WD(REG_WD), .REG_RDAT(REG_RDAT), .EE_CS(EE_CS), .EE_SK(EE_SK),
        .EE_DI(EE_DI), .EE_DO(EE_DO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(posedge CLK) rd_d <= REG_RD;

    // EEPROM model and output monitors, all evaluated mid-cycle.
    always @(negedge CLK) begin
        if (BUSY && !busy_p) begin
            cs_rises = 1; falls = 0; skr = 0; cslow = 0; polln = 0;
        end else begin
            if (EE_CS && !cs_p) cs_rises++;
            if (EE_CS && sk_p && !EE_SK) falls++;
            if (EE_CS && !sk_p && EE_SK) begin
                skr++;
                if (di_en) begin
                    if (di_q.size() == 0) chk("di_extra", 1, 0);
                    else chk("di_bit", EE_DI, di_q.pop_front());
                end
            end
            if (!EE_CS && BUSY) cslow++;
            if (EE_CS && cs_rises == 2) polln++;
        end
        case (mode)
            0: begin
                rom_sh = rom << (falls - 9);
                EE_DO = (falls >= 9 && falls <= 24) ? rom_sh[15] : 1'b0;
            end
            1:       EE_DO = (cs_rises == 2 && polln > 50);
            default: EE_DO = 1'b0;
        endcase
        busy_p = BUSY; cs_p = EE_CS; sk_p = EE_SK;
        if (rd_d) begin
            if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk(rd_tag_q.pop_front(), {24'h0, REG_RDAT}, {24'h0, rd_exp_q.pop_front()});
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        REG_WR = 1'b1; REG_A = a; REG_WD = d;
        @(negedge CLK);
        REG_WR = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        @(negedge CLK);
        rd_exp_q.push_back(exp); rd_tag_q.push_back(tag);
        REG_RD = 1'b1; REG_A = a;
        @(negedge CLK);
        REG_RD = 1'b0;
    endtask

    task automatic push_bits(input logic [31:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) di_q.push_back(v[i]);
    endtask

    // n counts clock edges from the edge that accepted the start.
    task automatic wait_idle(input string tag, input int maxc, output int cnt);
        cnt = 1;
        while (BUSY && cnt < maxc) begin
            @(negedge CLK);
            cnt++;
        end
        chk({tag, "_timeout"}, BUSY, 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_cs", EE_CS, 0);
        chk("rst_sk", EE_SK, 0);
        chk("rst_di", EE_DI, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rdat", REG_RDAT, 0);
        RST = 1'b0;
        rd(0, 8'h00, "rst_data_lo");
        rd(1, 8'h00, "rst_data_hi");
        rd(2, 8'h00, "rst_cmd_lo");
        rd(3, 8'h00, "rst_cmd_hi");
        rd(4, 8'h00, "rst_ctrl");
        rd(5, 8'hFF, "off5");
        rd(7, 8'hFF, "off7");

        // READ of BEEFh
        mode = 0; di_en = 1'b1;
        wr(2, 8'h85);
        push_bits(32'h185, 9); push_bits(32'h0, 16);
        wr(4, 8'h10);
        wait_idle("t1", 400, n);
        chk("t1_latency", n, 107);
        chk("t1_sk_pulses", skr, 25);
        chk("t1_di_left", di_q.size(), 0);
        rd(4, 8'h01, "t1_ctrl");
        rd(0, 8'hEF, "t1_data_lo");
        rd(1, 8'hBE, "t1_data_hi");

        // simultaneous write and read returns the old value
        @(negedge CLK);
        rd_exp_q.push_back(8'hEF); rd_tag_q.push_back("wrrd_old");
        REG_WR = 1'b1; REG_RD = 1'b1; REG_A = 3'd0; REG_WD = 8'h77;
        @(negedge CLK);
        REG_WR = 1'b0; REG_RD = 1'b0;
        rd(0, 8'h77, "wrrd_new");

        // WRITE 1234h with busy poll
        wr(0, 8'h34); wr(1, 8'h12); wr(2, 8'h45);
        mode = 1;
        push_bits(32'h145, 9); push_bits(32'h1234, 16);
        wr(4, 8'h20);
        wait_idle("t2", 500, n);
        chk("t2_sk_pulses", skr, 25);
        chk("t2_cs_low", cslow, 4);
        chk("t2_poll_cs", cs_rises, 2);
        chk("t2_di_left", di_q.size(), 0);
        rd(4, 8'h01, "t2_ctrl");

        // WRITE with DO stuck low -> timeout
        mode = 2;
        push_bits(32'h145, 9); push_bits(32'h1234, 16);
        wr(4, 8'h20);
        wait_idle("t3", 600, n);
        chk("t3_poll_len", polln, 100);
        chk("t3_cs", EE_CS, 0);
        rd(4, 8'h03, "t3_ctrl");
        wr(4, 8'h01);
        rd(4, 8'h00, "t3_clear");

        // EWEN command only
        mode = 0;
        wr(2, 8'h30);
        push_bits(32'h130, 9);
        wr(4, 8'h40);
        wait_idle("t4", 300, n);
        chk("t4_sk_pulses", skr, 9);
        chk("t4_no_poll", cs_rises, 1);
        chk("t4_di_left", di_q.size(), 0);
        rd(4, 8'h01, "t4_ctrl");

        // abort during command phase
        di_en = 1'b0;
        wr(2, 8'h85);
        wr(4, 8'h10);
        repeat (10) @(negedge CLK);
        chk("t5_busy", BUSY, 1);
        wr(0, 8'hAA);
        wr(4, 8'h80);
        chk("t5_cs", EE_CS, 0);
        chk("t5_sk", EE_SK, 0);
        chk("t5_busy_off", BUSY, 0);
        rd(0, 8'h34, "t5_data_lo");
        rd(1, 8'h12, "t5_data_hi");
        rd(4, 8'h00, "t5_ctrl");

        // reset during WDATA
        wr(2, 8'h45);
        wr(4, 8'h20);
        repeat (45) @(negedge CLK);
        chk("t6_in_write", EE_CS, 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_cs", EE_CS, 0);
        chk("t6_sk", EE_SK, 0);
        chk("t6_di", EE_DI, 0);
        chk("t6_busy", BUSY, 0);
        chk("t6_rdat", REG_RDAT, 0);
        RST = 1'b0;
        rd(0, 8'h00, "t6_data_lo");
        rd(1, 8'h00, "t6_data_hi");
        rd(4, 8'h00, "t6_ctrl");
        wr(2, 8'h85);
        di_en = 1'b1;
        push_bits(32'h185, 9); push_bits(32'h0, 16);
        wr(4, 8'h10);
        wait_idle("t6r", 400, n);
        chk("t6r_latency", n, 107);
        chk("t6r_di_left", di_q.size(), 0);
        rd(0, 8'hEF, "t6r_data_lo");
        rd(1, 8'hBE, "t6r_data_hi");
        rd(4, 8'h01, "t6r_ctrl");

        repeat (3) @(negedge CLK);
        chk("rd_left", rd_exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
